rs_age_sel: RTL and testbench
=============================

Name: rs_age_sel

Overview:
- Parametrised reservation station; next generation of the single-channel integer RS.
- Depth, operand width, ROB tag width and number of result-broadcast (CDB) channels are parameters.
- Selects the oldest ready entry, not the lowest index.
- Feeds an execution unit through a registered valid/ready handshake with backpressure, so multi-cycle or stalled functional units can share one RS.

Parameters:
- ENTRIES, 8, number of RS slots (power of two, ≥2).
- IDX_W, 3, log2(ENTRIES).
- ROB_W, 4, ROB tag width.
- XLEN, 32, operand/result width.
- OP_W, 8, opcode field width.
- NUM_CDB, 2, number of broadcast wakeup channels.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; all state frozen when low
- clear  in  1  flush (branch mispredict); acts only when rdy_in high
- dec_valid  in  1  decoder presents an instruction
- dec_op  in  OP_W  opcode
- dec_vj / dec_vk  in  XLEN  operand values, valid when no dependency
- dec_has_dep_j / dec_has_dep_k  in  1  operand waits on a ROB tag
- dec_qj / dec_qk  in  ROB_W  producing ROB tags
- dec_rob_id  in  ROB_W  destination ROB tag
- rs_full  out  1  no free slot
- rs_count  out  IDX_W+1  occupied slots
- cdb_valid  in  NUM_CDB  per-channel broadcast valid
- cdb_rob_id  in  NUM_CDB*ROB_W  flattened tags; channel c at [c*ROB_W +: ROB_W]
- cdb_value  in  NUM_CDB*XLEN  flattened values
- ex_valid  out  1  execution output slot holds an op
- ex_ready  in  1  execution unit accepts
- ex_op  out  OP_W  dispatched opcode
- ex_lhs / ex_rhs  out  XLEN  dispatched operands
- ex_rob_id  out  ROB_W  dispatched destination tag

Behaviour:
- Clock and reset: single clock clk_in; rst_in is synchronous, active-high and overrides rdy_in.
- Reset state: all entries invalid, age state cleared, ex_valid=0, ex_op/ex_lhs/ex_rhs/ex_rob_id=0, rs_count=0, rs_full=0.
- rdy_in=0: no state changes; outputs hold.
- clear with rdy_in=1: all entries invalidated, ex_valid←0, rs_count←0. Overrides dec_valid, wakeup and dispatch in that cycle.
- Entry fields: valid, op, vj, vk, dj, dk, qj, qk, rob_id, plus age ordering.
  - Age is an ENTRIES×ENTRIES older-than matrix; a newly written entry is younger than every valid entry.
- Insert:
  - Condition: dec_valid && !rs_full; write into the lowest-index free slot.
  - dec_valid while rs_full is ignored; the decoder must hold.
  - Full is judged on the pre-edge count, so a slot freed by dispatch in the same cycle is not reused until the next cycle.
- Insert bypass: if dec_has_dep_x and any cdb_valid[c] with cdb_rob_id[c]==dec_qx in the same cycle, store that value with dx=0.
- Wakeup: every valid entry with dx=1 and qx matching a valid CDB channel captures the value and sets dx←0 at the edge.
  - Multiple matching channels: the lowest channel index wins.
  - j and k may wake from different channels in the same cycle.
- Ready: an entry is ready when valid && !dj && !dk, evaluated on registered state. A value woken at edge t is dispatchable in the cycle after t.
- Dispatch:
  - Output slot may load when !ex_valid || ex_ready.
  - If it may load and any entry is ready, the oldest ready entry moves into ex_* at the edge, ex_valid←1, and the entry is freed.
  - If it may load and no entry is ready, ex_valid←0 when ex_ready was high.
  - ex_* is stable while ex_valid && !ex_ready.
- Latency: a dependency-free insert at edge t shows ex_valid=1 after edge t+1, given an empty output slot and no older ready entries. Sustained throughput is 1 dispatch/cycle with ex_ready held high.
- Count: rs_count += insert − dispatch; rs_full = (rs_count==ENTRIES), registered-derived. Simultaneous insert and dispatch leave the count unchanged.
- Operands are passed unmodified; no arithmetic inside the block.

Test Plan:
- Insert 3 independent ops (rob 1,2,3) back-to-back, ex_ready=1 → ex_rob_id 1,2,3 on consecutive cycles; first ex_valid two edges after the first insert.
- Insert rob 5 (qj=2, dep), then rob 6 (no dep); broadcast cdb0 tag 2 value 0x1234 → rob 6 dispatches first; rob 5 follows with ex_lhs=0x1234.
- Fill 8 entries, hold ex_ready=0 → rs_full=1, rs_count=8, ex_* stable; a ninth dec_valid is dropped. Raise ex_ready → oldest rob dispatched, rs_full drops next cycle.
- Insert with qj=7 while cdb1 broadcasts tag 7 value 0xAA in the same cycle → entry stored ready; ex_lhs=0xAA. Tag 7 on both channels with different values → channel 0 value taken.
- Four entries pending plus ex_valid=1, assert clear → next cycle ex_valid=0, rs_count=0; a concurrent dec_valid is not stored.
- rdy_in=0 for 3 cycles during CDB broadcasts and ex_ready=1 → no wakeup, no dispatch, outputs unchanged. rst_in high with rdy_in=0 → reset values next cycle.

Source files
------------

// File: rtl/rs_age_sel.sv
// Reservation station with age-matrix oldest-ready selection, multi-channel CDB
// wakeup with insert bypass, and a registered valid/ready dispatch slot.
module rs_age_sel #(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = 3,
  parameter int ROB_W   = 4,
  parameter int XLEN    = 32,
  parameter int OP_W    = 8,
  parameter int NUM_CDB = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear,
  input  logic                     dec_valid,
  input  logic [OP_W-1:0]          dec_op,
  input  logic [XLEN-1:0]          dec_vj,
  input  logic [XLEN-1:0]          dec_vk,
  input  logic                     dec_has_dep_j,
  input  logic                     dec_has_dep_k,
  input  logic [ROB_W-1:0]         dec_qj,
  input  logic [ROB_W-1:0]         dec_qk,
  input  logic [ROB_W-1:0]         dec_rob_id,
  output logic                     rs_full,
  output logic [IDX_W:0]           rs_count,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_rob_id,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_value,
  output logic                     ex_valid,
  input  logic                     ex_ready,
  output logic [OP_W-1:0]          ex_op,
  output logic [XLEN-1:0]          ex_lhs,
  output logic [XLEN-1:0]          ex_rhs,
  output logic [ROB_W-1:0]         ex_rob_id
);

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(ENTRIES);

  logic [ENTRIES-1:0] valid_q, valid_d, dj_q, dj_d, dk_q, dk_d;
  logic [OP_W-1:0]    op_q  [ENTRIES];
  logic [OP_W-1:0]    op_d  [ENTRIES];
  logic [XLEN-1:0]    vj_q  [ENTRIES];
  logic [XLEN-1:0]    vj_d  [ENTRIES];
  logic [XLEN-1:0]    vk_q  [ENTRIES];
  logic [XLEN-1:0]    vk_d  [ENTRIES];
  logic [ROB_W-1:0]   qj_q  [ENTRIES];
  logic [ROB_W-1:0]   qj_d  [ENTRIES];
  logic [ROB_W-1:0]   qk_q  [ENTRIES];
  logic [ROB_W-1:0]   qk_d  [ENTRIES];
  logic [ROB_W-1:0]   rob_q [ENTRIES];
  logic [ROB_W-1:0]   rob_d [ENTRIES];
  // older_q[i][j] set means entry i was inserted before entry j
  logic [ENTRIES-1:0] older_q [ENTRIES];
  logic [ENTRIES-1:0] older_d [ENTRIES];
  logic [IDX_W:0]     count_q, count_d;
  logic               ex_valid_q, ex_valid_d;
  logic [OP_W-1:0]    ex_op_q, ex_op_d;
  logic [XLEN-1:0]    ex_lhs_q, ex_lhs_d, ex_rhs_q, ex_rhs_d;
  logic [ROB_W-1:0]   ex_rob_q, ex_rob_d;

  logic [ENTRIES-1:0] ready_vec, sel_vec;
  logic [IDX_W-1:0]   sel_idx, free_idx;
  logic               any_ready, ins, can_load, disp;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ready_vec[i] = valid_q[i] && !dj_q[i] && !dk_q[i];
    end
  end

  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      sel_vec[i] = ready_vec[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if (j != i && ready_vec[j] && older_q[j][i]) sel_vec[i] = 1'b0;
      end
    end
  end

  always_comb begin
    sel_idx  = '0;
    free_idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (sel_vec[i])  sel_idx  = IDX_W'(i);
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    valid_d    = valid_q;
    dj_d       = dj_q;
    dk_d       = dk_q;
    op_d       = op_q;
    vj_d       = vj_q;
    vk_d       = vk_q;
    qj_d       = qj_q;
    qk_d       = qk_q;
    rob_d      = rob_q;
    older_d    = older_q;
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_lhs_d   = ex_lhs_q;
    ex_rhs_d   = ex_rhs_q;
    ex_rob_d   = ex_rob_q;

    any_ready = |ready_vec;
    ins       = dec_valid && !rs_full;
    can_load  = !ex_valid_q || ex_ready;
    disp      = can_load && any_ready;

    // Channels scanned high to low so the lowest matching channel wins
    for (int i = 0; i < ENTRIES; i++) begin
      for (int c = NUM_CDB-1; c >= 0; c--) begin
        if (valid_q[i] && cdb_valid[c]) begin
          if (dj_q[i] && cdb_rob_id[c*ROB_W +: ROB_W] == qj_q[i]) begin
            vj_d[i] = cdb_value[c*XLEN +: XLEN];
            dj_d[i] = 1'b0;
          end
          if (dk_q[i] && cdb_rob_id[c*ROB_W +: ROB_W] == qk_q[i]) begin
            vk_d[i] = cdb_value[c*XLEN +: XLEN];
            dk_d[i] = 1'b0;
          end
        end
      end
    end

    if (disp) begin
      ex_valid_d       = 1'b1;
      ex_op_d          = op_q[sel_idx];
      ex_lhs_d         = vj_q[sel_idx];
      ex_rhs_d         = vk_q[sel_idx];
      ex_rob_d         = rob_q[sel_idx];
      valid_d[sel_idx] = 1'b0;
    end else if (can_load) begin
      ex_valid_d = 1'b0;
    end

    if (ins) begin
      valid_d[free_idx] = 1'b1;
      op_d[free_idx]    = dec_op;
      rob_d[free_idx]   = dec_rob_id;
      vj_d[free_idx]    = dec_vj;
      vk_d[free_idx]    = dec_vk;
      dj_d[free_idx]    = dec_has_dep_j;
      dk_d[free_idx]    = dec_has_dep_k;
      qj_d[free_idx]    = dec_qj;
      qk_d[free_idx]    = dec_qk;
      for (int c = NUM_CDB-1; c >= 0; c--) begin
        if (cdb_valid[c] && dec_has_dep_j && cdb_rob_id[c*ROB_W +: ROB_W] == dec_qj) begin
          vj_d[free_idx] = cdb_value[c*XLEN +: XLEN];
          dj_d[free_idx] = 1'b0;
        end
        if (cdb_valid[c] && dec_has_dep_k && cdb_rob_id[c*ROB_W +: ROB_W] == dec_qk) begin
          vk_d[free_idx] = cdb_value[c*XLEN +: XLEN];
          dk_d[free_idx] = 1'b0;
        end
      end
      older_d[free_idx] = '0;
      for (int j = 0; j < ENTRIES; j++) begin
        older_d[j][free_idx] = valid_q[j];
      end
    end

    count_d = count_q + (IDX_W+1)'(ins) - (IDX_W+1)'(disp);

    if (clear) begin
      valid_d    = '0;
      ex_valid_d = 1'b0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q    <= '0;
      dj_q       <= '0;
      dk_q       <= '0;
      count_q    <= '0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_lhs_q   <= '0;
      ex_rhs_q   <= '0;
      ex_rob_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]    <= '0;
        vj_q[i]    <= '0;
        vk_q[i]    <= '0;
        qj_q[i]    <= '0;
        qk_q[i]    <= '0;
        rob_q[i]   <= '0;
        older_q[i] <= '0;
      end
    end else if (rdy_in) begin
      valid_q    <= valid_d;
      dj_q       <= dj_d;
      dk_q       <= dk_d;
      count_q    <= count_d;
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_lhs_q   <= ex_lhs_d;
      ex_rhs_q   <= ex_rhs_d;
      ex_rob_q   <= ex_rob_d;
      op_q       <= op_d;
      vj_q       <= vj_d;
      vk_q       <= vk_d;
      qj_q       <= qj_d;
      qk_q       <= qk_d;
      rob_q      <= rob_d;
      older_q    <= older_d;
    end
  end

  assign rs_full   = (count_q == FULL_CNT);
  assign rs_count  = count_q;
  assign ex_valid  = ex_valid_q;
  assign ex_op     = ex_op_q;
  assign ex_lhs    = ex_lhs_q;
  assign ex_rhs    = ex_rhs_q;
  assign ex_rob_id = ex_rob_q;

endmodule

// File: tb/tb_rs_age_sel.sv
// Directed self-checking bench for rs_age_sel: ordering, wakeup, bypass,
// backpressure/full, clear, rdy_in freeze and reset.
module tb_rs_age_sel;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear;
  logic        dec_valid;
  logic [7:0]  dec_op;
  logic [31:0] dec_vj, dec_vk;
  logic        dec_has_dep_j, dec_has_dep_k;
  logic [3:0]  dec_qj, dec_qk, dec_rob_id;
  logic        rs_full;
  logic [3:0]  rs_count;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_id;
  logic [63:0] cdb_value;
  logic        ex_valid, ex_ready;
  logic [7:0]  ex_op;
  logic [31:0] ex_lhs, ex_rhs;
  logic [3:0]  ex_rob_id;

  int check_count = 0;
  int error_count = 0;

  rs_age_sel dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .dec_valid(dec_valid), .dec_op(dec_op), .dec_vj(dec_vj), .dec_vk(dec_vk),
    .dec_has_dep_j(dec_has_dep_j), .dec_has_dep_k(dec_has_dep_k),
    .dec_qj(dec_qj), .dec_qk(dec_qk), .dec_rob_id(dec_rob_id),
    .rs_full(rs_full), .rs_count(rs_count),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_lhs(ex_lhs), .ex_rhs(ex_rhs), .ex_rob_id(ex_rob_id)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] rob, input logic [31:0] vj,
                               input logic [31:0] vk, input logic hj,
                               input logic [3:0] qj, input logic hk,
                               input logic [3:0] qk);
    dec_valid     = 1'b1;
    dec_rob_id    = rob;
    dec_op        = {4'h4, rob};
    dec_vj        = vj;
    dec_vk        = vk;
    dec_has_dep_j = hj;
    dec_qj        = qj;
    dec_has_dep_k = hk;
    dec_qk        = qk;
  endtask

  task automatic setCdb(input int ch, input logic [3:0] tag, input logic [31:0] val);
    cdb_valid[ch]         = 1'b1;
    cdb_rob_id[ch*4 +: 4] = tag;
    cdb_value[ch*32 +: 32] = val;
  endtask

  task automatic idle();
    dec_valid = 1'b0;
    cdb_valid = '0;
  endtask

  task automatic doReset();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    clear  = 1'b0;
    idle();
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  initial begin
    ex_ready = 1'b0;
    dec_op = '0; dec_vj = '0; dec_vk = '0; dec_rob_id = '0;
    dec_has_dep_j = 1'b0; dec_has_dep_k = 1'b0; dec_qj = '0; dec_qk = '0;
    cdb_rob_id = '0; cdb_value = '0;
    doReset();
    checkOutput("rst_ex_valid", 64'(ex_valid), 0);
    checkOutput("rst_count", 64'(rs_count), 0);
    checkOutput("rst_full", 64'(rs_full), 0);
    checkOutput("rst_rob", 64'(ex_rob_id), 0);
    checkOutput("rst_lhs", 64'(ex_lhs), 0);

    // Back-to-back independent ops
    ex_ready = 1'b1;
    applyStimulus(4'd1, 32'h11, 32'h21, 0, 0, 0, 0); tick();
    checkOutput("b2b_lat0", 64'(ex_valid), 0);
    checkOutput("b2b_cnt1", 64'(rs_count), 1);
    applyStimulus(4'd2, 32'h12, 32'h22, 0, 0, 0, 0); tick();
    checkOutput("b2b_v1", 64'(ex_valid), 1);
    checkOutput("b2b_rob1", 64'(ex_rob_id), 1);
    checkOutput("b2b_lhs1", 64'(ex_lhs), 32'h11);
    checkOutput("b2b_rhs1", 64'(ex_rhs), 32'h21);
    checkOutput("b2b_op1", 64'(ex_op), 8'h41);
    applyStimulus(4'd3, 32'h13, 32'h23, 0, 0, 0, 0); tick();
    checkOutput("b2b_rob2", 64'(ex_rob_id), 2);
    checkOutput("b2b_cnt", 64'(rs_count), 1);
    idle(); tick();
    checkOutput("b2b_rob3", 64'(ex_rob_id), 3);
    checkOutput("b2b_cnt0", 64'(rs_count), 0);
    tick();
    checkOutput("b2b_drain", 64'(ex_valid), 0);

    // Younger ready entry overtakes older waiting one
    applyStimulus(4'd5, 32'hDEAD, 32'h55, 1, 4'd2, 0, 0); tick();
    applyStimulus(4'd6, 32'h66, 32'h76, 0, 0, 0, 0); tick();
    checkOutput("age_none", 64'(ex_valid), 0);
    idle(); setCdb(0, 4'd2, 32'h1234); tick();
    checkOutput("age_rob6", 64'(ex_rob_id), 6);
    checkOutput("age_lhs6", 64'(ex_lhs), 32'h66);
    idle(); tick();
    checkOutput("wake_rob5", 64'(ex_rob_id), 5);
    checkOutput("wake_lhs5", 64'(ex_lhs), 32'h1234);
    checkOutput("wake_v5", 64'(ex_valid), 1);
    tick();
    checkOutput("wake_drain", 64'(ex_valid), 0);

    // Insert bypass from channel 1, then both channels match (channel 0 wins)
    applyStimulus(4'd7, 32'hDEAD, 32'h77, 1, 4'd7, 0, 0); setCdb(1, 4'd7, 32'hAA); tick();
    idle(); tick();
    checkOutput("byp_rob7", 64'(ex_rob_id), 7);
    checkOutput("byp_lhs", 64'(ex_lhs), 32'hAA);
    checkOutput("byp_rhs", 64'(ex_rhs), 32'h77);
    applyStimulus(4'd8, 32'h88, 32'hDEAD, 0, 0, 1, 4'd7);
    setCdb(0, 4'd7, 32'hB0); setCdb(1, 4'd7, 32'hB1); tick();
    checkOutput("byp_gap", 64'(ex_valid), 0);
    idle(); tick();
    checkOutput("byp_rob8", 64'(ex_rob_id), 8);
    checkOutput("byp_ch0", 64'(ex_rhs), 32'hB0);

    // Stored entry: j and k wake from different channels in one cycle
    applyStimulus(4'd9, 32'hDEAD, 32'hBEEF, 1, 4'd3, 1, 4'd4); tick();
    idle(); tick();
    checkOutput("jk_wait", 64'(ex_valid), 0);
    setCdb(0, 4'd3, 32'hC0); setCdb(1, 4'd4, 32'hD1); tick();
    checkOutput("jk_notyet", 64'(ex_valid), 0);
    idle(); tick();
    checkOutput("jk_rob9", 64'(ex_rob_id), 9);
    checkOutput("jk_lhs", 64'(ex_lhs), 32'hC0);
    checkOutput("jk_rhs", 64'(ex_rhs), 32'hD1);

    // Fill under backpressure; rob1 parks in the output slot
    doReset();
    ex_ready = 1'b0;
    for (int r = 1; r <= 9; r++) begin
      applyStimulus(4'(r), 32'(r) * 32'h101, 32'(r), 0, 0, 0, 0);
      tick();
      if (r == 5) checkOutput("full_stall5", 64'(ex_rob_id), 1);
    end
    checkOutput("full_cnt", 64'(rs_count), 8);
    checkOutput("full_flag", 64'(rs_full), 1);
    checkOutput("full_exv", 64'(ex_valid), 1);
    applyStimulus(4'd10, 32'hA0A, 32'd10, 0, 0, 0, 0); tick();
    checkOutput("full_drop_cnt", 64'(rs_count), 8);
    checkOutput("full_stable", 64'(ex_rob_id), 1);
    checkOutput("full_lhs", 64'(ex_lhs), 32'h101);
    ex_ready = 1'b1; tick();
    checkOutput("full_rob2", 64'(ex_rob_id), 2);
    checkOutput("full_cnt7", 64'(rs_count), 7);
    checkOutput("full_drop", 64'(rs_full), 0);
    idle();
    for (int r = 3; r <= 9; r++) begin
      tick();
      checkOutput("drain_rob", 64'(ex_rob_id), 64'(r));
    end
    tick();
    checkOutput("drain_empty", 64'(ex_valid), 0);
    checkOutput("drain_cnt", 64'(rs_count), 0);

    // Flush with pending entries and a concurrent insert
    doReset();
    ex_ready = 1'b0;
    for (int r = 1; r <= 5; r++) begin
      applyStimulus(4'(r), 32'(r), 32'(r), 0, 0, 0, 0);
      tick();
    end
    checkOutput("clr_pre_cnt", 64'(rs_count), 4);
    checkOutput("clr_pre_v", 64'(ex_valid), 1);
    clear = 1'b1; applyStimulus(4'd6, 32'h6, 32'h6, 0, 0, 0, 0); tick();
    clear = 1'b0; idle();
    checkOutput("clr_exv", 64'(ex_valid), 0);
    checkOutput("clr_cnt", 64'(rs_count), 0);
    ex_ready = 1'b1; tick();
    checkOutput("clr_nostore", 64'(ex_valid), 0);
    checkOutput("clr_cnt2", 64'(rs_count), 0);

    // rdy_in low freezes everything; reset overrides it
    doReset();
    ex_ready = 1'b0;
    applyStimulus(4'd1, 32'h31, 32'h41, 0, 0, 0, 0); tick();
    applyStimulus(4'd2, 32'hDEAD, 32'h42, 1, 4'd5, 0, 0); tick();
    idle();
    checkOutput("frz_pre_rob", 64'(ex_rob_id), 1);
    rdy_in = 1'b0; ex_ready = 1'b1;
    setCdb(0, 4'd5, 32'h55);
    applyStimulus(4'd3, 32'h33, 32'h43, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("frz_exv", 64'(ex_valid), 1);
      checkOutput("frz_rob", 64'(ex_rob_id), 1);
      checkOutput("frz_cnt", 64'(rs_count), 1);
    end
    rdy_in = 1'b1; idle(); tick();
    checkOutput("frz_nowake", 64'(ex_valid), 0);
    checkOutput("frz_cnt_after", 64'(rs_count), 1);
    tick();
    checkOutput("frz_still", 64'(ex_valid), 0);
    rst_in = 1'b1; rdy_in = 1'b0; tick();
    rst_in = 1'b0; rdy_in = 1'b1;
    checkOutput("rstov_cnt", 64'(rs_count), 0);
    checkOutput("rstov_rob", 64'(ex_rob_id), 0);
    checkOutput("rstov_lhs", 64'(ex_lhs), 0);
    checkOutput("rstov_exv", 64'(ex_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
